// File: rtl/down_counter_if.sv
// Handshake bundle for the loadable down counter.
// The master drives the controls and the slave (counter) returns its count and status.
interface down_counter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, en, abort,
    input  q, busy, done
  );

  modport slave (
    input  start, load_val, en, abort,
    output q, busy, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter/timer: counts load_val to zero on enabled clocks, pulses done
// for one cycle, then idles or reloads. Outputs registered; start is ignored while running.
module down_counter #(
  parameter int WIDTH       = 8,
  parameter int AUTO_RELOAD = 0
) (
  input  logic           clk,
  input  logic           reset,
  down_counter_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;

  logic w_load_nz;
  logic w_reload_nz;
  logic w_last;

  assign w_load_nz   = |bus.load_val;
  assign w_reload_nz = |r_reload;
  assign w_last      = (r_q == ONE);

  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // busy/done are set from the next state so they stay aligned with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q      <= bus.load_val;
            r_reload <= bus.load_val;
            if (w_load_nz) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_q     <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.en) begin
            r_q <= r_q - ONE;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.abort) begin
            r_q     <= '0;
            r_state <= S_IDLE;
          end else if (bus.start) begin
            r_q      <= bus.load_val;
            r_reload <= bus.load_val;
            if (w_load_nz) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if ((AUTO_RELOAD != 0) && w_reload_nz) begin
            r_q     <= r_reload;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_q     <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_q     <= '0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: one-shot and auto-reload instances, vector table,
// corner-case sequences and randomized traffic against a behavioural model.
module tb_down_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  down_counter_if #(.WIDTH(8)) b0 ();
  down_counter_if #(.WIDTH(8)) b1 ();

  down_counter #(.WIDTH(8), .AUTO_RELOAD(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  down_counter #(.WIDTH(8), .AUTO_RELOAD(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] lv;
    logic       en;
    logic       ab;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[$];

  // Model: mode 0 = idle, 1 = counting, 2 = terminal cycle.
  int m_mode[2];
  int m_q[2];
  int m_rel[2];

  function automatic vec_t mk(logic r, logic s, logic [7:0] lv, logic e, logic a,
                              logic [7:0] q, logic b, logic d);
    vec_t v;
    v.rst = r; v.start = s; v.lv = lv; v.en = e; v.ab = a;
    v.q = q; v.busy = b; v.done = d;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(int k, logic s, logic [7:0] lv, logic e, logic a);
    if (k == 0) begin
      b0.start = s; b0.load_val = lv; b0.en = e; b0.abort = a;
    end else begin
      b1.start = s; b1.load_val = lv; b1.en = e; b1.abort = a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(string name, int k, int q, int bz, int dn);
    if (k == 0) begin
      chk({name, ".q"}, 32'(b0.q), 32'(q));
      chk({name, ".busy"}, 32'(b0.busy), 32'(bz));
      chk({name, ".done"}, 32'(b0.done), 32'(dn));
    end else begin
      chk({name, ".q"}, 32'(b1.q), 32'(q));
      chk({name, ".busy"}, 32'(b1.busy), 32'(bz));
      chk({name, ".done"}, 32'(b1.done), 32'(dn));
    end
  endtask

  task automatic load_model(int k, int lv);
    m_q[k]    = lv;
    m_rel[k]  = lv;
    m_mode[k] = (lv != 0) ? 1 : 2;
  endtask

  task automatic model_step(int k, int autor, bit r, bit s, int lv, bit e, bit a);
    if (r) begin
      m_mode[k] = 0; m_q[k] = 0; m_rel[k] = 0;
    end else if (m_mode[k] == 0) begin
      if (s) load_model(k, lv);
    end else if (m_mode[k] == 1) begin
      if (a) begin
        m_mode[k] = 0; m_q[k] = 0;
      end else if (e) begin
        m_q[k] = m_q[k] - 1;
        if (m_q[k] == 0) m_mode[k] = 2;
      end
    end else begin
      if (a) begin
        m_mode[k] = 0; m_q[k] = 0;
      end else if (s) begin
        load_model(k, lv);
      end else if (autor != 0 && m_rel[k] != 0) begin
        m_q[k] = m_rel[k]; m_mode[k] = 1;
      end else begin
        m_mode[k] = 0; m_q[k] = 0;
      end
    end
  endtask

  initial begin
    int ar_q[8];
    drive(0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);

    // Table (one-shot instance): load 5, abort mid-count, load 0, start in RUN, restart in DONE.
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 5, 1, 0, 5, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 6, 0, 0, 6, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 5, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 2, 1, 0, 2, 1, 0));
    vt.push_back(mk(0, 1, 9, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 3, 0, 0, 3, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst;
      drive(0, vt[i].start, vt[i].lv, vt[i].en, vt[i].ab);
      tick();
      chk3($sformatf("vec%0d", i), 0, vt[i].q, vt[i].busy, vt[i].done);
    end
    drive(0, 0, 0, 0, 0);

    // en toggling: only enabled edges decrement; done after the sixth one.
    drive(0, 1, 6, 0, 0);
    tick();
    chk3("tog_load", 0, 6, 1, 0);
    begin
      int ecount = 0;
      for (int k = 0; k < 12; k++) begin
        drive(0, 0, 0, (k % 2) == 0, 0);
        tick();
        if ((k % 2) == 0) ecount++;
        if (k == 11)
          chk3($sformatf("tog%0d", k), 0, 0, 0, 0);
        else
          chk3($sformatf("tog%0d", k), 0, 6 - ecount, (ecount < 6) ? 1 : 0,
               (ecount == 6 && k == 10) ? 1 : 0);
      end
    end

    // Auto-reload: period L+1, and a start in the DONE cycle takes the new value.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk3("ar_rst", 1, 0, 0, 0);
    ar_q = '{3, 2, 1, 0, 3, 2, 1, 0};
    drive(1, 1, 3, 1, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      drive(1, 0, 0, 1, 0);
      chk3($sformatf("ar%0d", k), 1, ar_q[k], (ar_q[k] != 0) ? 1 : 0, (ar_q[k] == 0) ? 1 : 0);
    end
    drive(1, 1, 7, 1, 0);
    tick();
    chk3("ar_restart", 1, 7, 1, 0);
    drive(1, 0, 0, 1, 0);
    tick();
    chk3("ar_restart2", 1, 6, 1, 0);
    drive(1, 0, 0, 0, 1);
    tick();
    chk3("ar_abort", 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Full-range load, reset at 0x80, then a normal restart.
    drive(0, 1, 8'hFF, 1, 0);
    tick();
    chk3("ff_load", 0, 255, 1, 0);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 127; k++) tick();
    chk3("ff_mid", 0, 128, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk3("ff_rst", 0, 0, 0, 0);
    drive(0, 1, 2, 1, 0);
    tick();
    chk3("post_rst0", 0, 2, 1, 0);
    drive(0, 0, 0, 1, 0);
    tick();
    chk3("post_rst1", 0, 1, 1, 0);
    tick();
    chk3("post_rst2", 0, 0, 0, 1);
    tick();
    chk3("post_rst3", 0, 0, 0, 0);

    // Randomized traffic on both instances against the model.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 2; k++) model_step(k, k, 1'b1, 0, 0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      reset = r;
      for (int k = 0; k < 2; k++) begin
        bit s, e, a;
        int lv;
        s  = ($urandom_range(0, 5) == 0);
        e  = ($urandom_range(0, 3) != 0);
        a  = ($urandom_range(0, 24) == 0);
        lv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4))
                                          : int'($urandom_range(0, 40));
        if ($urandom_range(0, 49) == 0) lv = 255;
        drive(k, s, 8'(lv), e, a);
        model_step(k, k, r, s, lv, e, a);
      end
      tick();
      for (int k = 0; k < 2; k++)
        chk3($sformatf("rnd%0d_u%0d", c, k), k, m_q[k], (m_mode[k] == 1) ? 1 : 0,
             (m_mode[k] == 2) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
